// File: rtl/fp_result_scoreboard_if.sv
// Operand/result/flag bundle between the FP mult/div unit environment and its scoreboard.
interface fp_result_scoreboard_if #(
    parameter int W     = 32,
    parameter int CNT_W = 16
);
    logic             en;
    logic             sel;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     R;
    logic             io_flag;
    logic             dz_flag;
    logic             clr;
    logic             chk_valid;
    logic             mismatch;
    logic [3:0]       mismatch_code;
    logic [CNT_W-1:0] checked_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             err_sticky;
    logic [3:0]       first_err_code;

    modport master (
        output en, sel, a, b, R, io_flag, dz_flag, clr,
        input  chk_valid, mismatch, mismatch_code, checked_cnt, err_cnt, err_sticky, first_err_code
    );

    modport slave (
        input  en, sel, a, b, R, io_flag, dz_flag, clr,
        output chk_valid, mismatch, mismatch_code, checked_cnt, err_cnt, err_sticky, first_err_code
    );
endinterface

// File: rtl/fp_result_scoreboard.sv
// Pipelined special-operand checker for the FP mult/div unit: classifies each issued op,
// delays the expectation by the unit latency and compares it with the returned result and flags.
module fp_result_scoreboard #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int R_DLY = 23,
    parameter int CNT_W = 16,
    parameter int DAZ   = 0
) (
    input logic                   clk,
    input logic                   arst,
    fp_result_scoreboard_if.slave bus
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic [W-1:0] ONE = {2'b00, {(EXP_W-1){1'b1}}, {MAN_W{1'b0}}};

    typedef enum logic [2:0] {EC_GEN, EC_NAN, EC_INF, EC_ZERO, EC_EXACT} exp_class_t;

    typedef struct packed {
        logic         valid;
        exp_class_t   cls;
        logic [W-1:0] word;
        logic         sign;
        logic         io;
        logic         dz;
    } stage_t;

    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic             a_zero, a_norm, a_inf, a_nan;
    logic             b_zero, b_inf, b_nan;
    logic             s;
    stage_t           cap;
    stage_t           dly [R_DLY];
    stage_t           cmp;
    logic [W-1:0]     r_q;
    logic             io_q, dz_q, r_nan;
    logic [3:0]       code;

    logic             chk_valid_q, mismatch_q, err_sticky_q;
    logic [3:0]       code_q, first_err_q;
    logic [CNT_W-1:0] checked_q, err_q;

    assign a_exp = bus.a[W-2:MAN_W];
    assign a_man = bus.a[MAN_W-1:0];
    assign b_exp = bus.b[W-2:MAN_W];
    assign b_man = bus.b[MAN_W-1:0];
    assign s     = bus.a[W-1] ^ bus.b[W-1];

    // With DAZ a subnormal collapses into the signed-zero class.
    always_comb begin
        a_zero = (a_exp == '0) && ((a_man == '0) || (DAZ != 0));
        a_norm = (a_exp != '0) && (a_exp != '1);
        a_inf  = (a_exp == '1) && (a_man == '0);
        a_nan  = (a_exp == '1) && (a_man != '0);
        b_zero = (b_exp == '0) && ((b_man == '0) || (DAZ != 0));
        b_inf  = (b_exp == '1) && (b_man == '0);
        b_nan  = (b_exp == '1) && (b_man != '0);
    end

    always_comb begin
        cap       = '0;
        cap.valid = bus.en;
        cap.sign  = s;
        cap.cls   = EC_GEN;
        if (a_nan || b_nan) begin
            cap.cls = EC_NAN;
            cap.io  = 1'b1;
        end else if (!bus.sel) begin
            if ((a_inf && b_zero) || (a_zero && b_inf)) begin
                cap.cls = EC_NAN;
                cap.io  = 1'b1;
            end else if (a_inf || b_inf) begin
                cap.cls = EC_INF;
            end else if (a_zero || b_zero) begin
                cap.cls = EC_ZERO;
            end else if (bus.b == ONE && a_norm) begin
                cap.cls  = EC_EXACT;
                cap.word = bus.a;
            end
        end else begin
            if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                cap.cls = EC_NAN;
                cap.io  = 1'b1;
            end else if (!a_inf && !a_zero && b_zero) begin
                cap.cls = EC_INF;
                cap.dz  = 1'b1;
            end else if (a_zero) begin
                cap.cls = EC_ZERO;
            end else if (a_inf) begin
                cap.cls = EC_INF;
            end else if (b_inf) begin
                cap.cls = EC_ZERO;
            end else if (a_norm && bus.a == bus.b) begin
                cap.cls  = EC_EXACT;
                cap.word = ONE;
            end else if (bus.b == ONE) begin
                cap.cls  = EC_EXACT;
                cap.word = bus.a;
            end
        end
        if (cap.cls == EC_INF) cap.word = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        if (cap.cls == EC_ZERO) cap.word = {s, {(W-1){1'b0}}};
        if (cap.cls == EC_EXACT) cap.sign = cap.word[W-1];
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            for (int i = 0; i < R_DLY; i++) dly[i] <= '0;
            cmp  <= '0;
            r_q  <= '0;
            io_q <= 1'b0;
            dz_q <= 1'b0;
        end else begin
            dly[0] <= cap;
            for (int i = 1; i < R_DLY; i++) dly[i] <= dly[i-1];
            cmp  <= dly[R_DLY-1];
            r_q  <= bus.R;
            io_q <= bus.io_flag;
            dz_q <= bus.dz_flag;
        end
    end

    assign r_nan = (r_q[W-2:MAN_W] == '1) && (r_q[MAN_W-1:0] != '0);

    always_comb begin
        code = '0;
        if (cmp.valid) begin
            case (cmp.cls)
                EC_NAN:   code[0] = !r_nan;
                EC_GEN:   code[1] = r_q[W-1] != cmp.sign;
                EC_EXACT: begin
                    code[0] = r_q[W-2:0] != cmp.word[W-2:0];
                    code[1] = r_q[W-1] != cmp.word[W-1];
                end
                default:  begin
                    code[0] = r_q[W-2:0] != cmp.word[W-2:0];
                    code[1] = r_q[W-1] != cmp.sign;
                end
            endcase
            code[2] = io_q != cmp.io;
            code[3] = dz_q != cmp.dz;
        end
    end

    // clr wins over a coincident result: the pulse still shows, the counters do not move.
    always_ff @(posedge clk) begin
        if (arst) begin
            chk_valid_q  <= 1'b0;
            mismatch_q   <= 1'b0;
            code_q       <= '0;
            checked_q    <= '0;
            err_q        <= '0;
            err_sticky_q <= 1'b0;
            first_err_q  <= '0;
        end else begin
            chk_valid_q <= cmp.valid;
            mismatch_q  <= |code;
            code_q      <= code;
            if (bus.clr) begin
                checked_q    <= '0;
                err_q        <= '0;
                err_sticky_q <= 1'b0;
                first_err_q  <= '0;
            end else begin
                if (cmp.valid && checked_q != '1) checked_q <= checked_q + CNT_W'(1);
                if ((|code) && err_q != '1) err_q <= err_q + CNT_W'(1);
                if ((|code) && !err_sticky_q) begin
                    err_sticky_q <= 1'b1;
                    first_err_q  <= code;
                end
            end
        end
    end

    assign bus.chk_valid      = chk_valid_q;
    assign bus.mismatch       = mismatch_q;
    assign bus.mismatch_code  = code_q;
    assign bus.checked_cnt    = checked_q;
    assign bus.err_cnt        = err_q;
    assign bus.err_sticky     = err_sticky_q;
    assign bus.first_err_code = first_err_q;
endmodule

// File: tb/tb_fp_result_scoreboard.sv
// Directed bench for fp_result_scoreboard: one default instance and one with DAZ=1, CNT_W=4.
module tb_fp_result_scoreboard;
    localparam int R_DLY = 23;

    logic clk = 1'b0;
    logic arst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pulses;

    always #5 clk = ~clk;

    fp_result_scoreboard_if #(.W(32), .CNT_W(16)) f0 ();
    fp_result_scoreboard_if #(.W(32), .CNT_W(4))  f1 ();

    fp_result_scoreboard #(.EXP_W(8), .MAN_W(23), .R_DLY(R_DLY), .CNT_W(16), .DAZ(0)) u0 (
        .clk  (clk),
        .arst (arst),
        .bus  (f0)
    );

    fp_result_scoreboard #(.EXP_W(8), .MAN_W(23), .R_DLY(R_DLY), .CNT_W(4), .DAZ(1)) u1 (
        .clk  (clk),
        .arst (arst),
        .bus  (f1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op, return R/flags on the edge R_DLY later, stop just after outputs register.
    task automatic run_op0(input logic s, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] rv, input logic io, input logic dz);
        f0.sel = s; f0.a = av; f0.b = bv; f0.en = 1'b1;
        tick();
        f0.en = 1'b0;
        repeat (R_DLY-1) tick();
        f0.R = rv; f0.io_flag = io; f0.dz_flag = dz;
        tick();
        tick();
    endtask

    task automatic run_op1(input logic s, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] rv, input logic io, input logic dz);
        f1.sel = s; f1.a = av; f1.b = bv; f1.en = 1'b1;
        tick();
        f1.en = 1'b0;
        repeat (R_DLY-1) tick();
        f1.R = rv; f1.io_flag = io; f1.dz_flag = dz;
        tick();
        tick();
    endtask

    initial begin
        arst = 1'b1;
        f0.en = 0; f0.sel = 0; f0.a = 0; f0.b = 0; f0.R = 0; f0.io_flag = 0; f0.dz_flag = 0; f0.clr = 0;
        f1.en = 0; f1.sel = 0; f1.a = 0; f1.b = 0; f1.R = 0; f1.io_flag = 0; f1.dz_flag = 0; f1.clr = 0;
        repeat (3) tick();
        check("rst_chk_valid", 32'(f0.chk_valid), 0);
        check("rst_checked_cnt", 32'(f0.checked_cnt), 0);
        check("rst_err_sticky", 32'(f0.err_sticky), 0);
        check("rst_first_err", 32'(f0.first_err_code), 0);
        check("rst_u1_err_cnt", 32'(f1.err_cnt), 0);
        arst = 1'b0;

        // 3.0 / 0 -> +inf with divide-by-zero
        run_op0(1'b1, 32'h40400000, 32'h00000000, 32'h7F800000, 1'b0, 1'b1);
        check("div0_chk_valid", 32'(f0.chk_valid), 1);
        check("div0_mismatch", 32'(f0.mismatch), 0);
        check("div0_checked", 32'(f0.checked_cnt), 1);
        tick();
        check("div0_pulse_end", 32'(f0.chk_valid), 0);

        run_op0(1'b1, 32'h40400000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0);
        check("div0_nodz_mismatch", 32'(f0.mismatch), 1);
        check("div0_nodz_code", 32'(f0.mismatch_code), 32'h8);
        check("div0_nodz_err_cnt", 32'(f0.err_cnt), 1);
        check("div0_nodz_sticky", 32'(f0.err_sticky), 1);
        check("div0_nodz_first", 32'(f0.first_err_code), 32'h8);

        // inf * 0 -> NaN with invalid
        run_op0(1'b0, 32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0);
        check("infx0_code", 32'(f0.mismatch_code), 32'h5);
        check("infx0_err_cnt", 32'(f0.err_cnt), 2);
        check("infx0_first_held", 32'(f0.first_err_code), 32'h8);
        run_op0(1'b0, 32'h7F800000, 32'h00000000, 32'hFFC00001, 1'b1, 1'b0);
        check("infx0_nan_pass", 32'(f0.mismatch), 0);
        check("infx0_checked", 32'(f0.checked_cnt), 4);

        // pi * 1.0 -> exact pi
        run_op0(1'b0, 32'h40490FDB, 32'h3F800000, 32'h40490FDB, 1'b0, 1'b0);
        check("mul_one_pass", 32'(f0.mismatch), 0);
        // 2 * -3 returned positive: only sign is checked
        run_op0(1'b0, 32'h40000000, 32'hC0400000, 32'h40C00000, 1'b0, 1'b0);
        check("general_sign_code", 32'(f0.mismatch_code), 32'h2);
        // subnormal / 1.0 without DAZ -> exact subnormal
        run_op0(1'b1, 32'h00000001, 32'h3F800000, 32'h00000001, 1'b0, 1'b0);
        check("sub_div_one_pass", 32'(f0.mismatch), 0);
        run_op0(1'b1, 32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0);
        check("sub_div_one_code", 32'(f0.mismatch_code), 32'h1);
        check("sub_checked", 32'(f0.checked_cnt), 8);

        // Back-to-back issue with reset in cycle 10
        pulses = 0;
        f0.sel = 1'b1; f0.a = 32'h40400000; f0.b = 32'h00000000;
        f0.R = 32'h7F800000; f0.io_flag = 1'b0; f0.dz_flag = 1'b1;
        f0.en = 1'b1;
        for (int c = 0; c < 30; c++) begin
            arst = (c == 10);
            tick();
            if (f0.chk_valid) pulses++;
            if (c == 10) begin
                check("arst_checked_zero", 32'(f0.checked_cnt), 0);
                check("arst_sticky_zero", 32'(f0.err_sticky), 0);
            end
        end
        arst = 1'b0;
        f0.en = 1'b0;
        repeat (40) begin
            tick();
            if (f0.chk_valid) pulses++;
        end
        check("arst_pulses", 32'(pulses), 19);
        check("arst_checked_19", 32'(f0.checked_cnt), 19);
        check("arst_err_0", 32'(f0.err_cnt), 0);

        // DAZ instance: subnormal / 1.0 -> +0
        run_op1(1'b1, 32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0);
        check("daz_chk_valid", 32'(f1.chk_valid), 1);
        check("daz_mismatch", 32'(f1.mismatch), 0);

        // 20 forced mismatches on the 4-bit counters; first one differs in code
        f1.sel = 1'b0; f1.a = 32'h7F800000; f1.b = 32'h00000000;
        f1.R = 32'h00000000; f1.io_flag = 1'b0; f1.dz_flag = 1'b0;
        f1.en = 1'b1;
        repeat (20) tick();
        f1.en = 1'b0;
        repeat (3) tick();
        tick();
        f1.io_flag = 1'b1;
        repeat (20) tick();
        check("sat_err_cnt", 32'(f1.err_cnt), 15);
        check("sat_checked_cnt", 32'(f1.checked_cnt), 15);
        check("sat_sticky", 32'(f1.err_sticky), 1);
        check("sat_first_code", 32'(f1.first_err_code), 32'h5);
        f1.clr = 1'b1;
        tick();
        f1.clr = 1'b0;
        check("clr_err_cnt", 32'(f1.err_cnt), 0);
        check("clr_checked_cnt", 32'(f1.checked_cnt), 0);
        check("clr_sticky", 32'(f1.err_sticky), 0);
        check("clr_first_code", 32'(f1.first_err_code), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
